// File: rtl/comparator_4bit.sv
// -----------------------------------------------------------------------------
// comparator_4bit
//
// Registered 4-bit magnitude comparator. Every rising clock edge samples A, B
// and sign together and loads exactly one of equals / greater_than / less_than
// (A relative to B). sign selects unsigned (0..15) or two's-complement (-8..7)
// interpretation of both operands. Outputs come straight from flops; there is
// no combinational path from any input to any output.
//
// Ports
//   clk           in   1  rising-edge clock
//   rst           in   1  synchronous active-high reset; clears all outputs
//   sign          in   1  0 = unsigned operands, 1 = two's-complement operands
//   A             in   4  left operand
//   B             in   4  right operand
//   equals        out  1  registered, A == B
//   greater_than  out  1  registered, A > B under the sampled sign mode
//   less_than     out  1  registered, A < B under the sampled sign mode
//
// After reset all three outputs are 0 ("no result"); after the first edge with
// rst low the outputs are always one-hot.
// -----------------------------------------------------------------------------
module comparator_4bit (
   input  logic       clk,
   input  logic       rst,
   input  logic       sign,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       equals,
   output logic       greater_than,
   output logic       less_than
);

   // Next-state values for the three output flops.
   logic eq_d;
   logic gt_d;
   logic lt_d;

   // Per-bit difference and "A has the 1" flags.
   logic [3:0] diff;
   logic [3:0] a_high;

   // Set once the MSB-first scan has hit its deciding bit.
   logic       decided;

   assign diff   = A ^ B;
   assign a_high = A & ~B;

   // MSB-first scan: the first differing bit decides. In signed mode bit 3
   // carries weight -8, so the operand with a 1 there is the smaller one;
   // bits 2..0 are always compared as plain unsigned magnitude.
   always_comb begin
      gt_d    = 1'b0;
      lt_d    = 1'b0;
      decided = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (!decided && diff[i]) begin
            decided = 1'b1;
            if ((i == 3) && sign) begin
               gt_d = ~a_high[i];
               lt_d = a_high[i];
            end else begin
               gt_d = a_high[i];
               lt_d = ~a_high[i];
            end
         end
      end
      // No differing bit means bitwise equality, independent of sign mode.
      eq_d = ~decided;
   end

   // Output registers. Reset dominates the comparison result.
   always_ff @(posedge clk) begin
      if (rst) begin
         equals       <= 1'b0;
         greater_than <= 1'b0;
         less_than    <= 1'b0;
      end else begin
         equals       <= eq_d;
         greater_than <= gt_d;
         less_than    <= lt_d;
      end
   end

endmodule

// File: tb/tb_comparator_4bit.sv
// -----------------------------------------------------------------------------
// tb_comparator_4bit
//
// Self-checking bench for comparator_4bit. Expected {equals, greater_than,
// less_than} values are pushed onto a scoreboard queue when stimulus is driven
// (on the falling edge) and popped and compared #1 after the next rising edge.
// Covers a hand-written vector table, an exhaustive sweep of both sign modes,
// latency with mid-cycle input glitches, and reset behaviour.
// -----------------------------------------------------------------------------
module tb_comparator_4bit;

   logic       clk;
   logic       rst;
   logic       sign;
   logic [3:0] A;
   logic [3:0] B;
   logic       equals;
   logic       greater_than;
   logic       less_than;

   comparator_4bit dut (
      .clk          (clk),
      .rst          (rst),
      .sign         (sign),
      .A            (A),
      .B            (B),
      .equals       (equals),
      .greater_than (greater_than),
      .less_than    (less_than)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: expected {eq, gt, lt} plus a name for each pending check.
   logic [2:0] exp_q[$];
   string      name_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic       r;
      logic       s;
      logic [3:0] a;
      logic [3:0] b;
      logic [2:0] exp;
      string      name;
   } vec_t;

   vec_t vecs[$];

   // Reference model: plain integer compare.
   function automatic logic [2:0] model(input logic s, input logic [3:0] a,
                                        input logic [3:0] b);
      int va;
      int vb;
      va = a;
      vb = b;
      if (s) begin
         if (a[3]) va = va - 16;
         if (b[3]) vb = vb - 16;
      end
      if (va == vb)     return 3'b100;
      else if (va > vb) return 3'b010;
      else              return 3'b001;
   endfunction

   task automatic check_out();
      logic [2:0] got;
      logic [2:0] e;
      string      n;
      got = {equals, greater_than, less_than};
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got eq/gt/lt=%b with no expected entry", got);
         return;
      end
      e = exp_q.pop_front();
      n = name_q.pop_front();
      if (got !== e) begin
         n_fail++;
         $display("FAIL %s: got eq/gt/lt=%b expected %b (rst=%b sign=%b A=%h B=%h)",
                  n, got, e, rst, sign, A, B);
      end
   endtask

   // Drive one cycle of stimulus on the falling edge, check after the rise.
   task automatic apply(input logic r, input logic s, input logic [3:0] a,
                        input logic [3:0] b, input logic [2:0] exp, input string name);
      @(negedge clk);
      rst  = r;
      sign = s;
      A    = a;
      B    = b;
      exp_q.push_back(exp);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      check_out();
   endtask

   // Wiggle inputs mid-cycle and confirm the registered outputs hold.
   task automatic glitch(input logic [2:0] held, input string name);
      #1;
      sign = ~sign;
      A    = ~A;
      B    = B + 4'd5;
      #2;
      exp_q.push_back(held);
      name_q.push_back(name);
      check_out();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst  = 1'b1;
      sign = 1'b0;
      A    = 4'h0;
      B    = 4'h0;

      vecs.push_back('{1'b1, 1'b0, 4'hF, 4'h0, 3'b000, "reset_state"});
      vecs.push_back('{1'b0, 1'b0, 4'hF, 4'h0, 3'b010, "bound_u_15_gt_0"});
      vecs.push_back('{1'b0, 1'b1, 4'hF, 4'h0, 3'b001, "bound_s_m1_lt_0"});
      vecs.push_back('{1'b0, 1'b1, 4'h7, 4'h8, 3'b010, "ext_s_7_gt_m8"});
      vecs.push_back('{1'b0, 1'b0, 4'h7, 4'h8, 3'b001, "ext_u_7_lt_8"});
      vecs.push_back('{1'b0, 1'b0, 4'h5, 4'h5, 3'b100, "eq_u_5"});
      vecs.push_back('{1'b0, 1'b1, 4'h5, 4'h5, 3'b100, "eq_s_5"});
      vecs.push_back('{1'b0, 1'b0, 4'h8, 4'h8, 3'b100, "eq_u_8"});
      vecs.push_back('{1'b0, 1'b1, 4'h8, 4'h8, 3'b100, "eq_s_m8"});
      vecs.push_back('{1'b0, 1'b1, 4'h8, 4'hF, 3'b001, "s_m8_lt_m1"});
      vecs.push_back('{1'b0, 1'b0, 4'h8, 4'hF, 3'b001, "u_8_lt_15"});
      vecs.push_back('{1'b0, 1'b1, 4'hE, 4'hA, 3'b010, "s_m2_gt_m6"});

      for (int i = 0; i < vecs.size(); i++)
         apply(vecs[i].r, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name);

      // Exhaustive sweep, both sign modes.
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               apply(1'b0, s[0], a[3:0], b[3:0], model(s[0], a[3:0], b[3:0]),
                     $sformatf("exh_s%0d_a%0d_b%0d", s, a, b));
            end
         end
      end

      // Latency and hold: A=3,B=9 then A=9,B=3 on consecutive edges.
      apply(1'b0, 1'b0, 4'd3, 4'd9, 3'b001, "lat_k_lt");
      glitch(3'b001, "hold_k");
      apply(1'b0, 1'b0, 4'd9, 4'd3, 3'b010, "lat_k1_gt");
      glitch(3'b010, "hold_k1");

      // Back-to-back sign toggling on fixed operands.
      apply(1'b0, 1'b1, 4'hC, 4'h3, 3'b001, "toggle_s_m4_lt_3");
      apply(1'b0, 1'b0, 4'hC, 4'h3, 3'b010, "toggle_u_12_gt_3");
      apply(1'b0, 1'b1, 4'hC, 4'h3, 3'b001, "toggle_s_again");

      // Reset behaviour.
      apply(1'b1, 1'b0, 4'd5, 4'd2, 3'b000, "rst_edge1");
      apply(1'b1, 1'b0, 4'd5, 4'd2, 3'b000, "rst_edge2");
      apply(1'b0, 1'b0, 4'd5, 4'd2, 3'b010, "rst_release");
      apply(1'b0, 1'b0, 4'd2, 4'd5, 3'b001, "rst_run");
      apply(1'b1, 1'b1, 4'd2, 4'd5, 3'b000, "rst_mid");
      apply(1'b0, 1'b1, 4'd5, 4'd2, 3'b010, "rst_resume");

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_leftover: got %0d pending entries expected 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
